nonce_tx_queue: RTL and testbench
=================================

NONCE_TX_QUEUE -- requirements
Module: nonce_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, meaning the FIFO holds 2**DEPTH_LOG2 32-bit nonces.
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 4, meaning the maximum number of cycles to wait for tx_busy to rise after a send.
REQ-003 SHALL have port hash_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_nonce, input, 32, the golden nonce from the hub core.
REQ-006 SHALL have port in_valid, input, 1, a one-cycle strobe qualifying in_nonce.
REQ-007 SHALL have port out_word, output, 32, the nonce presented to the serial transmitter.
REQ-008 SHALL have port out_send, output, 1, a one-cycle start strobe to the serial transmitter.
REQ-009 SHALL have port tx_busy, input, 1, the transmitter busy flag.
REQ-010 SHALL have port fifo_count, output, DEPTH_LOG2+1, the current occupancy.
REQ-011 SHALL have port overflow, output, 1, a sticky flag set when any nonce was dropped.
REQ-012 SHALL have port drop_count, output, 8, a saturating count of dropped nonces.

Function
REQ-013 SHALL accept in_nonce when in_valid=1 and (fifo_count < 2**DEPTH_LOG2, or a pop occurs in the same cycle).
REQ-014 SHALL drop in_nonce when in_valid=1, the FIFO is full and no pop occurs; a drop sets overflow and increments drop_count, saturating at 255.
REQ-015 SHALL keep the FIFO in strict arrival order, with write and read pointers of DEPTH_LOG2 bits that wrap modulo depth.
REQ-016 SHALL run a read FSM with states IDLE, SEND, WAIT_HI and WAIT_LO.
REQ-017 SHALL, in IDLE with the FIFO not empty and tx_busy=0, pop the head into out_word and go to SEND; otherwise it stays in IDLE.
REQ-018 SHALL, in SEND, drive out_send=1 for exactly one cycle and go to WAIT_HI.
REQ-019 SHALL, in WAIT_HI, go to WAIT_LO when tx_busy=1, or return to IDLE after BUSY_TIMEOUT cycles without tx_busy=1.
REQ-020 SHALL, in WAIT_LO, go to IDLE when tx_busy=0.
REQ-021 SHALL hold out_word stable from SEND until the next pop.
REQ-022 SHALL, for a push into an empty FIFO with the FSM in IDLE and tx_busy=0, pop on the next cycle and assert out_send in the second cycle after in_valid was sampled.
REQ-023 SHALL, on a simultaneous push and pop, leave fifo_count unchanged; it increments on a push alone and decrements on a pop alone.
REQ-024 SHALL never pop when empty, and never assert out_send outside SEND.

Reset
REQ-025 SHALL, while reset=1, asynchronously clear the pointers, fifo_count, overflow, drop_count, out_send and out_word, and force the FSM to IDLE.
REQ-026 SHALL discard all queued nonces when reset is asserted mid-transfer and ignore tx_busy until IDLE is re-entered after reset release.
REQ-027 SHALL leave FIFO storage contents unreset, since they are unobservable.

Configuration
REQ-028 SHALL, with macro NONCE_DUP_FILTER_EN defined, silently discard any in_nonce equal to the last accepted nonce; such a discard does not count as a drop and does not set overflow.
REQ-029 SHALL clear the last-accepted register on reset when NONCE_DUP_FILTER_EN is defined, so the first nonce after reset is always accepted.
REQ-030 SHALL, without NONCE_DUP_FILTER_EN defined, accept every valid nonce subject only to REQ-013.

Verification
REQ-031 SHALL cover: single push of 0xDEADBEEF while idle with tx_busy=0 -> out_send=1 two cycles after in_valid, with out_word=0xDEADBEEF.
REQ-032 SHALL cover: 8 back-to-back pushes 0x1..0x8 with tx_busy held at 1 -> fifo_count=8, then on tx_busy release out_word follows 0x1..0x8 in order.
REQ-033 SHALL cover: 10 pushes into a full FIFO at depth 8 -> overflow=1, drop_count=2; 300 drops -> drop_count=255.
REQ-034 SHALL cover: a push in the same cycle as a pop at full -> the nonce is accepted, fifo_count stays 8 and overflow stays 0.
REQ-035 SHALL cover: tx_busy never rising after out_send -> the FSM returns to IDLE after 4 cycles and the next nonce is sent.
REQ-036 SHALL cover: with NONCE_DUP_FILTER_EN defined, 0xA5A5A5A5 pushed twice -> one send, drop_count=0; reset asserted in WAIT_LO -> fifo_count=0, out_send=0 and the FSM returns to IDLE.

Source files
------------

// File: rtl/nonce_tx_queue.sv
// nonce_tx_queue: buffers golden nonces from the hub core in a small FIFO and
// hands them one at a time to a serial transmitter via a start strobe,
// using the transmitter's busy flag (with a rise timeout) to pace sends.
//
// Optional feature macro: NONCE_DUP_FILTER_EN -- when defined, a nonce equal
// to the last accepted one is silently discarded (not counted as a drop).
//
// Ports:
//   hash_clk   - clock, all logic on rising edge
//   reset      - asynchronous active-high reset
//   in_nonce   - 32-bit nonce from hub core
//   in_valid   - one-cycle strobe qualifying in_nonce
//   out_word   - nonce presented to the serial transmitter
//   out_send   - one-cycle start strobe to the transmitter
//   tx_busy    - transmitter busy flag
//   fifo_count - current FIFO occupancy (DEPTH_LOG2+1 bits)
//   overflow   - sticky flag, set when any nonce was dropped
//   drop_count - saturating count of dropped nonces
module nonce_tx_queue #(
  parameter int unsigned DEPTH_LOG2   = 3,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                  hash_clk,
  input  logic                  reset,
  input  logic [31:0]           in_nonce,
  input  logic                  in_valid,
  output logic [31:0]           out_word,
  output logic                  out_send,
  input  logic                  tx_busy,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [TMO_W-1:0]   tmo_cnt_nxt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [31:0]        mem [DEPTH];

  logic               pop;
  logic               push;
  logic               drop;
  logic               dup;
  logic               full;
  logic               empty;

  assign full  = (fifo_count == CNT_W'(DEPTH));
  assign empty = (fifo_count == '0);

`ifdef NONCE_DUP_FILTER_EN
  // Last accepted nonce; last_valid keeps the first nonce after reset from
  // being mistaken for a duplicate of the cleared register.
  logic [31:0] last_nonce;
  logic        last_valid;

  assign dup = last_valid && (in_nonce == last_nonce);

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      last_nonce <= '0;
      last_valid <= 1'b0;
    end else if (push) begin
      last_nonce <= in_nonce;
      last_valid <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = in_valid && !dup && (!full || pop);
  assign drop = in_valid && !dup && full && !pop;

  // Read FSM next-state logic; pop is only ever raised from IDLE when not empty.
  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        state_nxt   = WAIT_HI;
        tmo_cnt_nxt = '0;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_nxt = WAIT_LO;
        end else if (tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1)) begin
          state_nxt = IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and registered transmitter outputs.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      out_send <= 1'b0;
      out_word <= '0;
    end else begin
      state    <= state_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
      out_send <= (state_nxt == SEND);
      if (pop) begin
        out_word <= mem[rd_ptr];
      end
    end
  end

  // FIFO storage carries no reset; its contents are invisible until written.
  always_ff @(posedge hash_clk) begin
    if (push) begin
      mem[wr_ptr] <= in_nonce;
    end
  end

  // Pointers wrap naturally at PTR_W bits; occupancy tracks push/pop balance.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Drop bookkeeping: sticky overflow and a counter saturating at 255.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_nonce_tx_queue.sv
// Directed testbench for nonce_tx_queue (default parameters, depth 8,
// busy timeout 4). Inputs change and outputs are sampled 1 ns after the
// rising edge.
module tb_nonce_tx_queue;

  logic        hash_clk;
  logic        reset;
  logic [31:0] in_nonce;
  logic        in_valid;
  logic [31:0] out_word;
  logic        out_send;
  logic        tx_busy;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_err = 0;

  nonce_tx_queue #(.DEPTH_LOG2(3), .BUSY_TIMEOUT(4)) dut (
    .hash_clk   (hash_clk),
    .reset      (reset),
    .in_nonce   (in_nonce),
    .in_valid   (in_valid),
    .out_word   (out_word),
    .out_send   (out_send),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial begin
    hash_clk = 1'b0;
    forever #5 hash_clk = ~hash_clk;
  end

  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_nonce = '0;
    tx_busy  = 1'b0;
    reset    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    in_nonce = '0;
    tx_busy  = 1'b0;
    reset    = 1'b1;
    #3;
    n_cmp++; if (out_send !== 1'b0) begin n_err++; $display("FAIL reset_out_send: got %0h want 0", out_send); end
    n_cmp++; if (out_word !== 32'h0) begin n_err++; $display("FAIL reset_out_word: got %0h want 0", out_word); end
    n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0h want 0", overflow); end
    n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_push();
    do_reset();
    in_nonce = 32'hDEADBEEF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL single_count1: got %0d want 1", fifo_count); end
    n_cmp++; if (out_send !== 1'b0) begin n_err++; $display("FAIL single_early_send: got %0h want 0", out_send); end
    tick();
    n_cmp++; if (out_send !== 1'b1) begin n_err++; $display("FAIL single_send: got %0h want 1", out_send); end
    n_cmp++; if (out_word !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_word: got %0h want deadbeef", out_word); end
    n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL single_count0: got %0d want 0", fifo_count); end
    tick();
    n_cmp++; if (out_send !== 1'b0) begin n_err++; $display("FAIL single_send_width: got %0h want 0", out_send); end
    n_cmp++; if (out_word !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_word_hold: got %0h want deadbeef", out_word); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    tx_busy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_nonce = 32'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL b2b_count8: got %0d want 8", fifo_count); end
    n_cmp++; if (out_send !== 1'b0) begin n_err++; $display("FAIL b2b_no_send_busy: got %0h want 0", out_send); end
    for (int k = 1; k <= 8; k++) begin
      tx_busy = 1'b0;
      n = 0;
      while (out_send !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      n_cmp++; if (out_send !== 1'b1) begin n_err++; $display("FAIL b2b_send_timeout: got %0h want 1 (word %0d)", out_send, k); end
      n_cmp++; if (out_word !== 32'(k)) begin n_err++; $display("FAIL b2b_order: got %0h want %0h", out_word, k); end
      tx_busy = 1'b1;
      tick();
      tick();
    end
    tx_busy = 1'b0;
    n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL b2b_drained: got %0d want 0", fifo_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_nonce = 32'h100 + 32'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_not_yet: got %0h want 0", overflow); end
    for (int i = 8; i < 10; i++) begin
      in_nonce = 32'h100 + 32'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL ovf_count: got %0d want 8", fifo_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0h want 1", overflow); end
    n_cmp++; if (drop_count !== 8'd2) begin n_err++; $display("FAIL ovf_drop2: got %0d want 2", drop_count); end
    for (int i = 0; i < 298; i++) begin
      in_nonce = 32'h200 + 32'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (drop_count !== 8'd255) begin n_err++; $display("FAIL ovf_saturate: got %0d want 255", drop_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0h want 1", overflow); end
    tx_busy = 1'b0;
  endtask

  task automatic test_push_pop_full();
    int n;
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_nonce = 32'h11 + 32'(i);
      in_valid = 1'b1;
      tick();
    end
    n_cmp++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL ppf_full: got %0d want 8", fifo_count); end
    in_nonce = 32'h19;
    in_valid = 1'b1;
    tx_busy  = 1'b0;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL ppf_count: got %0d want 8", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ppf_overflow: got %0h want 0", overflow); end
    n_cmp++; if (out_send !== 1'b1) begin n_err++; $display("FAIL ppf_send: got %0h want 1", out_send); end
    n_cmp++; if (out_word !== 32'h11) begin n_err++; $display("FAIL ppf_first: got %0h want 11", out_word); end
    tx_busy = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      tx_busy = 1'b0;
      n = 0;
      while (out_send !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      n_cmp++; if (out_send !== 1'b1) begin n_err++; $display("FAIL ppf_send_timeout: got %0h want 1", out_send); end
      n_cmp++; if (out_word !== 32'h12 + 32'(k)) begin n_err++; $display("FAIL ppf_order: got %0h want %0h", out_word, 32'h12 + 32'(k)); end
      tx_busy = 1'b1;
      tick();
      tick();
    end
    tx_busy = 1'b0;
    n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL ppf_drops: got %0d want 0", drop_count); end
  endtask

  task automatic test_busy_timeout();
    do_reset();
    in_nonce = 32'hAAAA0001;
    in_valid = 1'b1;
    tick();
    in_nonce = 32'hAAAA0002;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_send !== 1'b1) begin n_err++; $display("FAIL tmo_first_send: got %0h want 1", out_send); end
    n_cmp++; if (out_word !== 32'hAAAA0001) begin n_err++; $display("FAIL tmo_first_word: got %0h want aaaa0001", out_word); end
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_cmp++; if (out_send !== 1'b0) begin n_err++; $display("FAIL tmo_quiet: got %0h want 0 (cycle %0d)", out_send, c); end
    end
    tick();
    n_cmp++; if (out_send !== 1'b1) begin n_err++; $display("FAIL tmo_second_send: got %0h want 1", out_send); end
    n_cmp++; if (out_word !== 32'hAAAA0002) begin n_err++; $display("FAIL tmo_second_word: got %0h want aaaa0002", out_word); end
  endtask

  task automatic test_dup_filter();
    int sends;
    do_reset();
    in_nonce = 32'hA5A5A5A5;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    sends = (out_send === 1'b1) ? 1 : 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (out_send === 1'b1) sends++;
    end
`ifdef NONCE_DUP_FILTER_EN
    n_cmp++; if (sends !== 1) begin n_err++; $display("FAIL dup_sends: got %0d want 1", sends); end
`else
    n_cmp++; if (sends !== 2) begin n_err++; $display("FAIL dup_sends: got %0d want 2", sends); end
`endif
    n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL dup_drops: got %0d want 0", drop_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL dup_overflow: got %0h want 0", overflow); end
    // After reset the same value must be accepted again.
    do_reset();
    tx_busy  = 1'b1;
    in_nonce = 32'hA5A5A5A5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL dup_after_reset: got %0d want 1", fifo_count); end
    tx_busy = 1'b0;
  endtask

  task automatic test_reset_mid_transfer();
    do_reset();
    in_valid = 1'b1;
    in_nonce = 32'hC0DE0001;
    tick();
    in_nonce = 32'hC0DE0002;
    tick();
    in_nonce = 32'hC0DE0003;
    tick();
    in_valid = 1'b0;
    tx_busy  = 1'b1;
    tick();
    n_cmp++; if (fifo_count !== 4'd2) begin n_err++; $display("FAIL rmid_pre_count: got %0d want 2", fifo_count); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", fifo_count); end
    n_cmp++; if (out_send !== 1'b0) begin n_err++; $display("FAIL rmid_send: got %0h want 0", out_send); end
    n_cmp++; if (out_word !== 32'h0) begin n_err++; $display("FAIL rmid_word: got %0h want 0", out_word); end
    tick();
    reset = 1'b0;
    tick();
    tick();
    n_cmp++; if (out_send !== 1'b0) begin n_err++; $display("FAIL rmid_idle_busy: got %0h want 0", out_send); end
    tx_busy  = 1'b0;
    in_nonce = 32'hC0DE00FF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL rmid_discarded: got %0d want 1", fifo_count); end
    tick();
    n_cmp++; if (out_send !== 1'b1) begin n_err++; $display("FAIL rmid_resend: got %0h want 1", out_send); end
    n_cmp++; if (out_word !== 32'hC0DE00FF) begin n_err++; $display("FAIL rmid_word_after: got %0h want c0de00ff", out_word); end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_nonce = '0;
    tx_busy  = 1'b0;
    test_reset();
    test_single_push();
    test_back_to_back();
    test_overflow();
    test_push_pop_full();
    test_busy_timeout();
    test_dup_filter();
    test_reset_mid_transfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
